// File: rtl/alu_flag_stage_if.sv
// Operand/result bundle between the shifter-side driver and the ALU stage.
// The master drives operands; the slave returns the registered result and flags.
interface alu_flag_stage_if;
    logic        in_valid;
    logic [4:1]  ALU_OP;
    logic        S_bit;
    logic [32:1] A;
    logic [32:1] B;
    logic        Shift_Carry_Out;
    logic        Shift_Carry_Valid;
    logic [32:1] F;
    logic        out_valid;
    logic        out_write;
    logic [4:1]  NZCV;
    logic        Carry_flag;

    modport master (
        output in_valid,
        output ALU_OP,
        output S_bit,
        output A,
        output B,
        output Shift_Carry_Out,
        output Shift_Carry_Valid,
        input  F,
        input  out_valid,
        input  out_write,
        input  NZCV,
        input  Carry_flag
    );

    modport slave (
        input  in_valid,
        input  ALU_OP,
        input  S_bit,
        input  A,
        input  B,
        input  Shift_Carry_Out,
        input  Shift_Carry_Valid,
        output F,
        output out_valid,
        output out_write,
        output NZCV,
        output Carry_flag
    );
endinterface

// File: rtl/alu_flag_stage.sv
// ARM data-processing execute stage: 16 ALU ops, registered result,
// and the architectural NZCV register feeding carry back to the shifter.
module alu_flag_stage #(
    parameter logic [4:1] NZCV_RESET = 4'b0000
) (
    input  logic clk,
    input  logic rst,
    alu_flag_stage_if.slave bus
);

    typedef enum logic [3:0] {
        OP_AND = 4'h0,
        OP_EOR = 4'h1,
        OP_SUB = 4'h2,
        OP_RSB = 4'h3,
        OP_ADD = 4'h4,
        OP_ADC = 4'h5,
        OP_SBC = 4'h6,
        OP_RSC = 4'h7,
        OP_TST = 4'h8,
        OP_TEQ = 4'h9,
        OP_CMP = 4'hA,
        OP_CMN = 4'hB,
        OP_ORR = 4'hC,
        OP_MOV = 4'hD,
        OP_BIC = 4'hE,
        OP_MVN = 4'hF
    } alu_op_e;

    logic [32:1] f_q, f_d;
    logic        out_valid_q, out_valid_d;
    logic        out_write_q, out_write_d;
    logic [4:1]  nzcv_q, nzcv_d;

    alu_op_e     op;
    logic        c_cur;
    logic        is_arith;
    logic        is_test;
    logic [32:1] x_opnd;
    logic [32:1] y_opnd;
    logic        cin;
    logic [33:1] sum;
    logic [32:1] logic_res;
    logic [32:1] result;
    logic        res_n;
    logic        res_z;
    logic        res_c;
    logic        res_v;
    logic        flag_we;

    assign op    = alu_op_e'(bus.ALU_OP);
    assign c_cur = nzcv_q[2];

    // Adder operand selection; subtracts are X + ~Y + cin.
    always_comb begin
        is_arith = 1'b0;
        x_opnd   = bus.A;
        y_opnd   = bus.B;
        cin      = 1'b0;
        unique case (op)
            OP_SUB, OP_CMP: begin
                is_arith = 1'b1;
                y_opnd   = ~bus.B;
                cin      = 1'b1;
            end
            OP_RSB: begin
                is_arith = 1'b1;
                x_opnd   = bus.B;
                y_opnd   = ~bus.A;
                cin      = 1'b1;
            end
            OP_ADD, OP_CMN: begin
                is_arith = 1'b1;
            end
            OP_ADC: begin
                is_arith = 1'b1;
                cin      = c_cur;
            end
            OP_SBC: begin
                is_arith = 1'b1;
                y_opnd   = ~bus.B;
                cin      = c_cur;
            end
            OP_RSC: begin
                is_arith = 1'b1;
                x_opnd   = bus.B;
                y_opnd   = ~bus.A;
                cin      = c_cur;
            end
            default: begin
                is_arith = 1'b0;
            end
        endcase
    end

    assign sum = {1'b0, x_opnd} + {1'b0, y_opnd} + {32'b0, cin};

    always_comb begin
        is_test   = 1'b0;
        logic_res = '0;
        unique case (op)
            OP_AND: logic_res = bus.A & bus.B;
            OP_EOR: logic_res = bus.A ^ bus.B;
            OP_TST: begin
                logic_res = bus.A & bus.B;
                is_test   = 1'b1;
            end
            OP_TEQ: begin
                logic_res = bus.A ^ bus.B;
                is_test   = 1'b1;
            end
            OP_CMP, OP_CMN: is_test = 1'b1;
            OP_ORR: logic_res = bus.A | bus.B;
            OP_MOV: logic_res = bus.B;
            OP_BIC: logic_res = bus.A & ~bus.B;
            OP_MVN: logic_res = ~bus.B;
            default: logic_res = '0;
        endcase
    end

    // Flag generation; logical ops keep C when the shift amount was zero.
    always_comb begin
        result = is_arith ? sum[32:1] : logic_res;
        res_n  = result[32];
        res_z  = (result == '0);
        res_c  = nzcv_q[2];
        res_v  = nzcv_q[1];
        if (is_arith) begin
            res_c = sum[33];
            res_v = (x_opnd[32] == y_opnd[32]) &&
                    (sum[32] != x_opnd[32]);
        end else if (bus.Shift_Carry_Valid) begin
            res_c = bus.Shift_Carry_Out;
        end
    end

    assign flag_we = bus.in_valid && (bus.S_bit || is_test);

    always_comb begin
        f_d         = f_q;
        out_valid_d = 1'b0;
        out_write_d = 1'b0;
        nzcv_d      = nzcv_q;
        if (bus.in_valid) begin
            f_d         = result;
            out_valid_d = 1'b1;
            out_write_d = !is_test;
        end
        if (flag_we) begin
            nzcv_d = {res_n, res_z, res_c, res_v};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q         <= '0;
            out_valid_q <= 1'b0;
            out_write_q <= 1'b0;
            nzcv_q      <= NZCV_RESET;
        end else begin
            f_q         <= f_d;
            out_valid_q <= out_valid_d;
            out_write_q <= out_write_d;
            nzcv_q      <= nzcv_d;
        end
    end

    assign bus.F          = f_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_write  = out_write_q;
    assign bus.NZCV       = nzcv_q;
    assign bus.Carry_flag = nzcv_q[2];

endmodule

// File: tb/tb_alu_flag_stage.sv
// Directed scoreboard bench for alu_flag_stage: expectations are queued
// at drive time and checked one cycle later against the registered outputs.
module tb_alu_flag_stage;

    typedef struct packed {
        logic [32:1] f;
        logic        w;
        logic [4:1]  nzcv;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];

    alu_flag_stage_if bus_if ();

    alu_flag_stage #(
        .NZCV_RESET(4'b0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag, input logic [4:1] op,
                        input logic s, input logic [32:1] a,
                        input logic [32:1] b, input logic sco,
                        input logic scv, input logic [32:1] ef,
                        input logic ew, input logic [4:1] en);
        exp_t e;
        @(negedge clk);
        bus_if.in_valid          = 1'b1;
        bus_if.ALU_OP            = op;
        bus_if.S_bit             = s;
        bus_if.A                 = a;
        bus_if.B                 = b;
        bus_if.Shift_Carry_Out   = sco;
        bus_if.Shift_Carry_Valid = scv;
        e.f    = ef;
        e.w    = ew;
        e.nzcv = en;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty, observed %h expected entry",
                   tag, bus_if.F);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, 32'(bus_if.out_valid), 32'd1);
            chk({tag, "_F"}, bus_if.F, e.f);
            chk({tag, "_write"}, 32'(bus_if.out_write), 32'(e.w));
            chk({tag, "_nzcv"}, 32'(bus_if.NZCV), 32'(e.nzcv));
            chk({tag, "_cf"}, 32'(bus_if.Carry_flag), 32'(e.nzcv[2]));
        end
    endtask

    task automatic idle(input string tag, input logic [32:1] ef,
                        input logic [4:1] en);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        bus_if.S_bit    = 1'b1;
        bus_if.A        = 32'h1234_5678;
        bus_if.B        = 32'h0000_0001;
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, 32'(bus_if.out_valid), 32'd0);
        chk({tag, "_write"}, 32'(bus_if.out_write), 32'd0);
        chk({tag, "_F"}, bus_if.F, ef);
        chk({tag, "_nzcv"}, 32'(bus_if.NZCV), 32'(en));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus_if.in_valid          = 1'b0;
        bus_if.ALU_OP            = 4'h0;
        bus_if.S_bit             = 1'b0;
        bus_if.A                 = '0;
        bus_if.B                 = '0;
        bus_if.Shift_Carry_Out   = 1'b0;
        bus_if.Shift_Carry_Valid = 1'b0;
        #2;
        chk("rst_F", bus_if.F, 32'h0);
        chk("rst_valid", 32'(bus_if.out_valid), 32'd0);
        chk("rst_write", 32'(bus_if.out_write), 32'd0);
        chk("rst_nzcv", 32'(bus_if.NZCV), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Add overflow and carry-out
        step("adds_ovf", 4'h4, 1, 32'h7FFF_FFFF, 32'h1, 0, 0,
             32'h8000_0000, 1, 4'b1001);
        step("adds_wrap", 4'h4, 1, 32'hFFFF_FFFF, 32'h1, 0, 0,
             32'h0, 1, 4'b0110);
        // Compare ignores S_bit and suppresses the write
        step("cmp_lt", 4'hA, 0, 32'h5, 32'h7, 0, 0,
             32'hFFFF_FFFE, 0, 4'b1000);
        step("cmp_gt", 4'hA, 0, 32'h7, 32'h5, 0, 0,
             32'h2, 0, 4'b0010);
        step("movs_c", 4'hD, 1, 32'h0, 32'h8000_0000, 1, 1,
             32'h8000_0000, 1, 4'b1010);
        // Set C=0,V=1 then a logical op with no shifter carry keeps both
        step("adds_v", 4'h4, 1, 32'h7FFF_FFFF, 32'h1, 0, 0,
             32'h8000_0000, 1, 4'b1001);
        step("movs_nc", 4'hD, 1, 32'h0, 32'h8000_0000, 1, 0,
             32'h8000_0000, 1, 4'b1001);
        // Carry chain into ADC back to back
        step("adds_c", 4'h4, 1, 32'hFFFF_FFFF, 32'h1, 0, 0,
             32'h0, 1, 4'b0110);
        step("adc", 4'h5, 0, 32'h0, 32'h0, 0, 0,
             32'h1, 1, 4'b0110);
        step("cmp_clr", 4'hA, 0, 32'h5, 32'h7, 0, 0,
             32'hFFFF_FFFE, 0, 4'b1000);
        step("sbcs", 4'h6, 1, 32'h5, 32'h3, 0, 0,
             32'h1, 1, 4'b0010);
        step("add_ns", 4'h4, 0, 32'hFFFF_FFFF, 32'h1, 0, 0,
             32'h0, 1, 4'b0010);
        idle("idle1", 32'h0, 4'b0010);
        step("subs", 4'h2, 1, 32'h0, 32'h1, 0, 0,
             32'hFFFF_FFFF, 1, 4'b1000);
        step("rsbs", 4'h3, 1, 32'h10, 32'h30, 0, 0,
             32'h20, 1, 4'b0010);
        step("rscs", 4'h7, 1, 32'h3, 32'h1, 0, 0,
             32'hFFFF_FFFE, 1, 4'b1000);
        step("subs_v", 4'h2, 1, 32'h8000_0000, 32'h1, 0, 0,
             32'h7FFF_FFFF, 1, 4'b0011);
        step("ands", 4'h0, 1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1, 0,
             32'h0, 1, 4'b0111);
        step("eors", 4'h1, 1, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 1,
             32'hF0F0_F0F0, 1, 4'b1001);
        step("teq", 4'h9, 0, 32'h5, 32'h5, 1, 0,
             32'h0, 0, 4'b0101);
        step("tst", 4'h8, 0, 32'h8000_0000, 32'hC000_0000, 1, 1,
             32'h8000_0000, 0, 4'b1011);
        step("orr", 4'hC, 0, 32'h1, 32'h2, 0, 1,
             32'h3, 1, 4'b1011);
        step("bics", 4'hE, 1, 32'hFFFF_FFFF, 32'h0000_FFFF, 0, 0,
             32'hFFFF_0000, 1, 4'b1011);
        step("mvns", 4'hF, 1, 32'h0, 32'hFFFF_FFFF, 0, 0,
             32'h0, 1, 4'b0111);
        step("cmn", 4'hB, 0, 32'hFFFF_FFFF, 32'h1, 0, 0,
             32'h0, 0, 4'b0110);
        step("adds_pre", 4'h4, 1, 32'h7FFF_FFFF, 32'h1, 0, 0,
             32'h8000_0000, 1, 4'b1001);

        // Asynchronous reset in the middle of a cycle, op in flight
        @(negedge clk);
        bus_if.in_valid = 1'b1;
        bus_if.ALU_OP   = 4'h4;
        bus_if.S_bit    = 1'b1;
        bus_if.A        = 32'h7FFF_FFFF;
        bus_if.B        = 32'h1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_F", bus_if.F, 32'h0);
        chk("arst_valid", 32'(bus_if.out_valid), 32'd0);
        chk("arst_write", 32'(bus_if.out_write), 32'd0);
        chk("arst_nzcv", 32'(bus_if.NZCV), 32'h0);
        chk("arst_cf", 32'(bus_if.Carry_flag), 32'd0);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        rst = 1'b0;
        idle("idle_post", 32'h0, 4'b0000);
        step("post_rst", 4'h4, 1, 32'hFFFF_FFFF, 32'h1, 0, 0,
             32'h0, 1, 4'b0110);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
